// File: rtl/cmp_pkg.sv
// Shared types and default sizing for the pipelined comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_UNSIGNED = 2'd0,
    CMP_SIGNED   = 2'd1,
    CMP_FLOAT    = 2'd2,
    CMP_RSVD     = 2'd3
  } cmp_mode_e;

  localparam int CMP_WIDTH = 32;
  localparam int CMP_CHUNK = 8;
  localparam int CMP_EXP_W = 8;
  localparam int CMP_TAG_W = 4;

endpackage

// File: rtl/comparator_pipe_if.sv
// Operation/result bus of the pipelined comparator.
//
// Handshake: an operation transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. The producer
// holds in_valid/operands until the transfer, the comparator holds out_valid and
// the result flags/tag until the consumer takes them. in_ready may depend
// combinationally on out_ready; no other input-to-output path exists.
interface comparator_pipe_if
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int TAG_W = CMP_TAG_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             equal;
  logic             larger;
  logic             smaller;
  logic             unordered;
  logic [TAG_W-1:0] out_tag;

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, mode, in_tag, out_ready,
    input  in_ready, out_valid, equal, larger, smaller, unordered, out_tag
  );

  // Comparator side.
  modport slave (
    input  in_valid, a, b, mode, in_tag, out_ready,
    output in_ready, out_valid, equal, larger, smaller, unordered, out_tag
  );
endinterface

// File: rtl/comparator_chunk.sv
// Unsigned equal/greater compare of one CHUNK-wide slice, purely combinational.
module comparator_chunk
  import cmp_pkg::*;
#(
  parameter int CHUNK = CMP_CHUNK
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_eq,
  output logic             o_gt
);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a > i_b);
endmodule

// File: rtl/comparator_pipe.sv
// Two-stage comparator: stage 1 slices the conditioned operands into per-chunk
// eq/gt and captures sign/zero/NaN info, stage 2 merges slices MSB-first and
// resolves the mode-specific result flags.
module comparator_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH,
  parameter int CHUNK = CMP_CHUNK,
  parameter int EXP_W = CMP_EXP_W,
  parameter int TAG_W = CMP_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  comparator_pipe_if.slave  bus
);
  localparam int N      = WIDTH / CHUNK;
  localparam int FRAC_W = WIDTH - 1 - EXP_W;

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("comparator_pipe: WIDTH must be a multiple of CHUNK");
  end
  if (FRAC_W < 1) begin : g_bad_exp
    $error("comparator_pipe: EXP_W leaves no fraction bits");
  end

  // Pipeline enable: everything advances only when the output slot is free or
  // being drained this cycle.
  logic w_en;
  assign w_en         = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_en;

  cmp_mode_e        w_mode;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [N-1:0]     w_eq;
  logic [N-1:0]     w_gt;
  logic             w_nan_a;
  logic             w_nan_b;
  logic             w_zero;

  // Normalise the mode and condition operand MSBs so a plain unsigned slice
  // compare yields the right ordering (bias signs, or strip FP sign bits).
  always_comb begin
    w_mode = CMP_UNSIGNED;
    if (bus.mode == 2'd1) w_mode = CMP_SIGNED;
    if (bus.mode == 2'd2) w_mode = CMP_FLOAT;
    w_op_a = bus.a;
    w_op_b = bus.b;
    if (w_mode == CMP_SIGNED) begin
      w_op_a[WIDTH-1] = ~bus.a[WIDTH-1];
      w_op_b[WIDTH-1] = ~bus.b[WIDTH-1];
    end else if (w_mode == CMP_FLOAT) begin
      w_op_a[WIDTH-1] = 1'b0;
      w_op_b[WIDTH-1] = 1'b0;
    end
  end

  assign w_nan_a = (&bus.a[WIDTH-2 -: EXP_W]) & (|bus.a[FRAC_W-1:0]);
  assign w_nan_b = (&bus.b[WIDTH-2 -: EXP_W]) & (|bus.b[FRAC_W-1:0]);
  assign w_zero  = ~(|bus.a[WIDTH-2:0]) & ~(|bus.b[WIDTH-2:0]);

  for (genvar g = 0; g < N; g++) begin : g_chunk
    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
      .i_a  (w_op_a[g*CHUNK +: CHUNK]),
      .i_b  (w_op_b[g*CHUNK +: CHUNK]),
      .o_eq (w_eq[g]),
      .o_gt (w_gt[g])
    );
  end

  logic             r_s1_valid;
  logic [N-1:0]     r_s1_eq;
  logic [N-1:0]     r_s1_gt;
  cmp_mode_e        r_s1_mode;
  logic             r_s1_sign_a;
  logic             r_s1_sign_b;
  logic             r_s1_zero;
  logic             r_s1_nan_a;
  logic             r_s1_nan_b;
  logic [TAG_W-1:0] r_s1_tag;

  // Stage 1 register: capture slice results and FP side info; a cycle with
  // en=1 and no offered operation leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_eq     <= '0;
      r_s1_gt     <= '0;
      r_s1_mode   <= CMP_UNSIGNED;
      r_s1_sign_a <= 1'b0;
      r_s1_sign_b <= 1'b0;
      r_s1_zero   <= 1'b0;
      r_s1_nan_a  <= 1'b0;
      r_s1_nan_b  <= 1'b0;
      r_s1_tag    <= '0;
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_eq     <= w_eq;
      r_s1_gt     <= w_gt;
      r_s1_mode   <= w_mode;
      r_s1_sign_a <= bus.a[WIDTH-1];
      r_s1_sign_b <= bus.b[WIDTH-1];
      r_s1_zero   <= w_zero;
      r_s1_nan_a  <= w_nan_a;
      r_s1_nan_b  <= w_nan_b;
      r_s1_tag    <= bus.in_tag;
    end
  end

  logic w_mag_eq;
  logic w_mag_gt;
  logic w_equal;
  logic w_larger;
  logic w_smaller;
  logic w_unordered;

  // Merge slices MSB-first, then resolve flags for the operation's mode.
  always_comb begin
    w_mag_eq = 1'b1;
    w_mag_gt = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_mag_eq) begin
        w_mag_gt = r_s1_gt[i];
        w_mag_eq = r_s1_eq[i];
      end
    end
    w_equal     = 1'b0;
    w_larger    = 1'b0;
    w_smaller   = 1'b0;
    w_unordered = 1'b0;
    if (r_s1_mode == CMP_FLOAT) begin
      if (r_s1_nan_a | r_s1_nan_b) begin
        w_unordered = 1'b1;
      end else if (r_s1_zero) begin
        w_equal = 1'b1;
      end else if (r_s1_sign_a != r_s1_sign_b) begin
        w_larger  = ~r_s1_sign_a;
        w_smaller = r_s1_sign_a;
      end else if (r_s1_sign_a) begin
        w_equal   = w_mag_eq;
        w_larger  = ~w_mag_eq & ~w_mag_gt;
        w_smaller = w_mag_gt;
      end else begin
        w_equal   = w_mag_eq;
        w_larger  = w_mag_gt;
        w_smaller = ~w_mag_eq & ~w_mag_gt;
      end
    end else begin
      w_equal   = w_mag_eq;
      w_larger  = w_mag_gt;
      w_smaller = ~w_mag_eq & ~w_mag_gt;
    end
  end

  logic             r_out_valid;
  logic             r_equal;
  logic             r_larger;
  logic             r_smaller;
  logic             r_unordered;
  logic [TAG_W-1:0] r_out_tag;

  // Stage 2 register: result flags and tag, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_equal     <= 1'b0;
      r_larger    <= 1'b0;
      r_smaller   <= 1'b0;
      r_unordered <= 1'b0;
      r_out_tag   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_equal     <= w_equal;
      r_larger    <= w_larger;
      r_smaller   <= w_smaller;
      r_unordered <= w_unordered;
      r_out_tag   <= r_s1_tag;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.equal     = r_equal;
  assign bus.larger    = r_larger;
  assign bus.smaller   = r_smaller;
  assign bus.unordered = r_unordered;
  assign bus.out_tag   = r_out_tag;

endmodule

// File: tb/tb_comparator_pipe.sv
// Directed and random bench for comparator_pipe with a result scoreboard.
module tb_comparator_pipe;
  import cmp_pkg::*;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int EW = 4 + TW;
  localparam logic [31:0] SPECIALS [11] = '{
    32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
    32'h7FC0_0000, 32'h7F80_0001, 32'h3F80_0000, 32'hBF80_0000,
    32'h7FFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comparator_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  comparator_pipe #(.WIDTH(W), .CHUNK(8), .EXP_W(8), .TAG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [EW-1:0] mon_got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=progress", tag);
  endtask

  // Reference: {equal, larger, smaller, unordered, tag}
  function automatic logic [EW-1:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] m, input logic [TW-1:0] t);
    logic e, g, l, u, na, nb;
    logic [30:0] ma, mb;
    e = 1'b0; g = 1'b0; l = 1'b0; u = 1'b0;
    ma = a[30:0];
    mb = b[30:0];
    na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    case (m)
      2'd1: begin
        e = ($signed(a) == $signed(b));
        g = ($signed(a) >  $signed(b));
        l = ($signed(a) <  $signed(b));
      end
      2'd2: begin
        if (na || nb)                   u = 1'b1;
        else if (ma == 0 && mb == 0)    e = 1'b1;
        else if (a[31] != b[31]) begin  g = !a[31]; l = a[31]; end
        else if (!a[31]) begin          e = (ma == mb); g = (ma > mb); l = (ma < mb); end
        else begin                      e = (ma == mb); g = (ma < mb); l = (ma > mb); end
      end
      default: begin
        e = (a == b);
        g = (a > b);
        l = (a < b);
      end
    endcase
    return {e, g, l, u, t};
  endfunction

  // Output monitor: sampled mid-low-phase, after the driver has settled inputs.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.out_valid) begin
        chk("onehot", 32'($onehot({bus.equal, bus.larger, bus.smaller, bus.unordered})), 1);
        if (!bus.out_ready) chk("in_ready_stall", 32'(bus.in_ready), 0);
      end
      if (bus.out_ready) chk("in_ready_free", 32'(bus.in_ready), 1);
      if (bus.out_valid && bus.out_ready) begin
        mon_got = {bus.equal, bus.larger, bus.smaller, bus.unordered, bus.out_tag};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_output observed=%0h expected=none", mon_got);
        end else begin
          chk("result", 32'(mon_got), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m, input logic [TW-1:0] t, input logic rdy,
                      output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.mode      = m;
    bus.in_tag    = t;
    bus.out_ready = rdy;
    #1;
    acc = v && bus.in_ready && !rst;
    if (acc) exp_q.push_back(ref_model(a, b, m, t));
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, 32'd0, 32'd0, 2'd0, '0, 1'b1, acc);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] m, input logic [TW-1:0] t);
    logic acc;
    int n;
    n = 0;
    do begin
      step(1'b1, a, b, m, t, 1'b1, acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) fail_now("send_timeout");
  endtask

  // One op into an empty pipe; result must appear exactly two cycles later.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] m, input logic [TW-1:0] t, input logic [3:0] flags);
    logic acc;
    idle(3);
    step(1'b1, a, b, m, t, 1'b1, acc);
    chk({tag, "_acc"}, 32'(acc), 1);
    step(1'b0, 32'd0, 32'd0, 2'd0, '0, 1'b1, acc);
    chk({tag, "_lat1"}, 32'(bus.out_valid), 0);
    step(1'b0, 32'd0, 32'd0, 2'd0, '0, 1'b1, acc);
    chk({tag, "_lat2"}, 32'(bus.out_valid), 1);
    chk({tag, "_flags"}, 32'({bus.equal, bus.larger, bus.smaller, bus.unordered}), 32'(flags));
    chk({tag, "_tag"}, 32'(bus.out_tag), 32'(t));
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0, 1:    return SPECIALS[$urandom_range(0, 10)];
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    logic [31:0] ra, rb;
    int idx, n_before, sent, cyc, k;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = 2'd0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_flags", 32'({bus.equal, bus.larger, bus.smaller, bus.unordered}), 0);
    chk("rst_tag", 32'(bus.out_tag), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Directed compares
    directed("u_msb",    32'h8000_0000, 32'h7FFF_FFFF, 2'd0, 4'h1, 4'b0100);
    directed("s_msb",    32'h8000_0000, 32'h7FFF_FFFF, 2'd1, 4'h2, 4'b0010);
    directed("f_zeros",  32'h0000_0000, 32'h8000_0000, 2'd2, 4'h3, 4'b1000);
    directed("f_negs",   32'hBF80_0000, 32'hC000_0000, 2'd2, 4'h4, 4'b0100);
    directed("f_nan",    32'h7FC0_0000, 32'h3F80_0000, 2'd2, 4'h5, 4'b0001);
    directed("f_inf_eq", 32'h7F80_0000, 32'h7F80_0000, 2'd2, 4'h6, 4'b1000);
    directed("f_ninf",   32'h3F80_0000, 32'hFF80_0000, 2'd2, 4'h7, 4'b0100);
    directed("f_nan_b",  32'h7F80_0000, 32'h7F80_0001, 2'd2, 4'h8, 4'b0001);
    directed("rsvd_u",   32'h8000_0000, 32'h7FFF_FFFF, 2'd3, 4'h9, 4'b0100);
    directed("s_eq",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd1, 4'hA, 4'b1000);
    directed("u_small",  32'h0000_0100, 32'h0000_0101, 2'd0, 4'hB, 4'b0010);

    // Back-to-back with a three-cycle consumer stall
    idle(3);
    idx = 1;
    n_before = n_out;
    for (int c = 0; c < 14; c++) begin
      if (idx <= 4) begin
        step(1'b1, 32'(idx * 3), 32'd5, 2'd0, TW'(idx), !(c >= 3 && c <= 5), acc);
        if (acc) idx++;
      end else begin
        step(1'b0, 32'd0, 32'd0, 2'd0, '0, !(c >= 3 && c <= 5), acc);
      end
    end
    chk("bp_all_accepted", 32'(idx), 5);
    chk("bp_out_count", 32'(n_out - n_before), 4);

    // Reset with two operations in flight
    idle(3);
    send(32'd1, 32'd2, 2'd0, 4'hC);
    send(32'd9, 32'd2, 2'd0, 4'hD);
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #3;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_tag", 32'(bus.out_tag), 0);
    rst = 1'b0;
    #1;
    chk("flush_in_ready", 32'(bus.in_ready), 1);
    n_before = n_out;
    idle(4);
    chk("flush_no_stale", 32'(n_out - n_before), 0);
    directed("post_rst", 32'h0000_0007, 32'h0000_0003, 2'd0, 4'hE, 4'b0100);

    // Random traffic, all modes, random gaps and backpressure
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 40000) begin
      ra = rnd_op();
      case ($urandom_range(0, 7))
        0, 1:    rb = ra;
        2:       rb = ra ^ 32'h8000_0000;
        default: rb = rnd_op();
      endcase
      step($urandom_range(0, 4) != 0, ra, rb, 2'($urandom_range(0, 3)),
           TW'($urandom), $urandom_range(0, 3) != 0, acc);
      if (acc) sent++;
      cyc++;
    end
    if (sent < 10000) fail_now("random_budget");

    // Drain
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      idle(1);
      k++;
    end
    idle(2);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comparator_pipe.md
COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; SHALL be a multiple of CHUNK, else elaboration error.
REQ-002 Parameter CHUNK, default 8: slice width for stage-1 partial compares.
REQ-003 Parameter EXP_W, default 8: exponent field width for FP mode; FRAC_W = WIDTH-1-EXP_W.
REQ-004 Parameter TAG_W, default 4: sideband tag width carried alongside each operation.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  operation offered.
REQ-008 in_ready  out  1  operation accepted when in_valid & in_ready.
REQ-009 a, b  in  WIDTH  operands.
REQ-010 mode  in  2  cmp_mode_e: UNSIGNED=0, SIGNED=1 (two's complement), FLOAT=2 (IEEE-style sign/exp/frac), 3 reserved and treated as UNSIGNED.
REQ-011 in_tag  in  TAG_W  opaque tag.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes result when out_valid & out_ready.
REQ-014 equal, larger, smaller, unordered  out  1 each  a==b, a>b, a<b, NaN involved.
REQ-015 out_tag  out  TAG_W  in_tag of the operation producing the current result.

Function
REQ-016 Two register stages; latency exactly 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-017 Pipeline enable en = ~out_valid | out_ready; in_ready SHALL equal en; both stages advance only when en=1.
REQ-018 When en=0, all stage registers and outputs SHALL hold; no operation lost, duplicated or reordered.
REQ-019 A cycle with en=1 and in_valid=0 SHALL insert a bubble (stage-1 valid cleared).
REQ-020 Sustained throughput one operation per cycle while out_ready=1.
REQ-021 Stage 1: per-slice eq/gt for WIDTH/CHUNK slices; in SIGNED mode MSB of both operands inverted first; in FLOAT mode MSB masked to 0 (magnitude compare); registers signs, both-zero flag and NaN flags.
REQ-022 NaN = exponent all ones and fraction nonzero; infinities compare as ordinary magnitudes.
REQ-023 Stage 2: MSB-first priority combine of slice results into magnitude eq/gt.
REQ-024 UNSIGNED/SIGNED: equal=eq, larger=gt, smaller=~eq&~gt, unordered=0.
REQ-025 FLOAT, either NaN: unordered=1, equal=larger=smaller=0.
REQ-026 FLOAT, both magnitudes zero: equal=1 regardless of signs (+0 == -0).
REQ-027 FLOAT, signs differ (not both zero): positive operand larger.
REQ-028 FLOAT, both negative: magnitude gt/lt reversed; both positive: magnitude result direct.
REQ-029 Exactly one of equal/larger/smaller/unordered SHALL be 1 whenever out_valid=1.
REQ-030 Flag outputs and out_tag registered; values while out_valid=0 are don't-care but SHALL be 0 after reset.

Reset
REQ-031 rst=1 at a rising edge SHALL clear both stage valids, out_valid and all flag outputs and out_tag to 0, discarding in-flight operations.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deassertion.
REQ-033 rst has priority over en and in_valid in the same cycle.

Structure
REQ-034 Package cmp_pkg SHALL hold cmp_mode_e and default constants for WIDTH, CHUNK, EXP_W.
REQ-035 Sub-module comparator_chunk (parametrised CHUNK, unsigned eq/gt, combinational) instantiated WIDTH/CHUNK times in stage 1.

Verification
REQ-036 UNSIGNED a=0x8000_0000, b=0x7FFF_FFFF -> larger=1 at cycle 2; same operands SIGNED -> smaller=1.
REQ-037 FLOAT a=0x0000_0000, b=0x8000_0000 -> equal=1; a=0xBF80_0000 (-1.0), b=0xC000_0000 (-2.0) -> larger=1.
REQ-038 FLOAT a=0x7FC0_0000 (NaN), b=0x3F80_0000 -> unordered=1, others 0; a=b=0x7F80_0000 (+inf) -> equal=1.
REQ-039 Back-to-back 4 ops, tags 1..4, out_ready=0 cycles 3-5 -> in_ready=0 while out_valid & ~out_ready, results emerge tags 1,2,3,4 in order, none lost.
REQ-040 rst asserted with two ops in flight -> out_valid=0 next cycle, no stale result later; new op after reset completes in 2 cycles.
REQ-041 Random 10k ops all modes vs reference model -> zero mismatches; one-hot flag property holds every valid cycle.
